rr_merge_node: RTL and testbench

//  2:1 merge node for the binary-tree NoC that carries multiplier results to adder inputs.

---
 rtl/noc_pkg.sv | 31 +++
 rtl/noc_fifo.sv | 53 +++++
 rtl/rr_merge_node.sv | 93 +++++++++
 tb/tb_rr_merge_node.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared flit layout for the multiplier-to-adder reduction NoC.
// Holds the flit-width helper, the default field positions and the flit/grant types.
package noc_pkg;

  function automatic int flit_w(input int log_n_add, input int bit_width, input int val_bit);
    return val_bit + log_n_add + bit_width;
  endfunction

  localparam int LOG_N_ADD      = 6;
  localparam int BIT_WIDTH      = 16;
  localparam int VAL_BIT        = 1;
  localparam int LOG_BUFFER_LEN = 3;

  localparam int FLIT_W    = flit_w(LOG_N_ADD, BIT_WIDTH, VAL_BIT);
  localparam int VALID_POS = FLIT_W - 1;
  localparam int DEST_MSB  = FLIT_W - 2;
  localparam int DEST_LSB  = BIT_WIDTH;
  localparam int DATA_MSB  = BIT_WIDTH - 1;

  typedef struct packed {
    logic                 valid;
    logic [LOG_N_ADD-1:0] dest;
    logic [BIT_WIDTH-1:0] data;
  } flit_t;

  typedef enum logic {
    GRANT_1 = 1'b0,
    GRANT_2 = 1'b1
  } grant_e;

endpackage

// File: rtl/noc_fifo.sv
// Circular flit FIFO; head is the registered read slot, a push is visible one cycle later.
// Backpressure: full decodes the registered count only, so a same-cycle pop never admits a push.
module noc_fifo #(
  parameter int W         = 23,
  parameter int log_depth = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);

  localparam int DEPTH = 2 ** log_depth;

  logic [W-1:0]         mem [DEPTH];
  logic [log_depth-1:0] rd_ptr;
  logic [log_depth-1:0] wr_ptr;
  logic [log_depth:0]   count;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == (log_depth + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; pointers and count alone define what is buffered.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/rr_merge_node.sv
// 2:1 round-robin flit merge with per-input FIFOs and a registered output toward the root.
// Latency: push edge t -> out after edge t+1; out holds and FIFOs stall while full_out blocks it.
module rr_merge_node
  import noc_pkg::*;
#(
  parameter  int log_n_add      = 6,
  parameter  int bit_width      = 16,
  parameter  int val_bit        = 1,
  parameter  int log_buffer_len = 3,
  localparam int W              = flit_w(log_n_add, bit_width, val_bit)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_1,
  input  logic [W-1:0] in_2,
  output logic         full_1,
  output logic         full_2,
  output logic [W-1:0] out,
  input  logic         full_out,
  output logic         ovf
);

  logic [W-1:0] head_1, head_2;
  logic         empty_1, empty_2;
  logic         push_1, push_2;
  logic         pop_1, pop_2;
  logic         win_1, win_2;
  logic         ld;
  grant_e       last_grant;

  assign push_1 = in_1[W-1] && !full_1;
  assign push_2 = in_2[W-1] && !full_2;
  assign ld     = !out[W-1] || !full_out;
  assign pop_1  = ld && win_1;
  assign pop_2  = ld && win_2;

  noc_fifo #(.W(W), .log_depth(log_buffer_len)) u_fifo_1 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_1),
    .pop   (pop_1),
    .din   (in_1),
    .head  (head_1),
    .empty (empty_1),
    .full  (full_1)
  );

  noc_fifo #(.W(W), .log_depth(log_buffer_len)) u_fifo_2 (
    .clk   (clk),
    .rst   (rst),
    .push  (push_2),
    .pop   (pop_2),
    .din   (in_2),
    .head  (head_2),
    .empty (empty_2),
    .full  (full_2)
  );

  // Under contention the input that did not win last time goes first.
  always_comb begin
    win_1 = 1'b0;
    win_2 = 1'b0;
    if (!empty_1 && !empty_2) begin
      win_1 = (last_grant == GRANT_2);
      win_2 = (last_grant == GRANT_1);
    end else begin
      win_1 = !empty_1;
      win_2 = !empty_2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out        <= '0;
      last_grant <= GRANT_2;
      ovf        <= 1'b0;
    end else begin
      if ((in_1[W-1] && full_1) || (in_2[W-1] && full_2)) ovf <= 1'b1;
      if (ld) begin
        if (win_1) begin
          out        <= head_1;
          last_grant <= GRANT_1;
        end else if (win_2) begin
          out        <= head_2;
          last_grant <= GRANT_2;
        end else begin
          out <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rr_merge_node.sv
// Directed-plus-random bench for rr_merge_node against a queue-based merge model.
// Each cycle drives inputs on the falling edge, advances the model on the rising edge, compares on the next fall.
module tb_rr_merge_node;
  import noc_pkg::*;

  localparam int W     = FLIT_W;
  localparam int DEPTH = 2 ** LOG_BUFFER_LEN;
  localparam flit_t IDLE = '0;

  logic         clk      = 1'b0;
  logic         rst      = 1'b0;
  logic [W-1:0] in_1     = '0;
  logic [W-1:0] in_2     = '0;
  logic         full_out = 1'b0;
  logic [W-1:0] out;
  logic         full_1, full_2, ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  flit_t        q1[$];
  flit_t        q2[$];
  flit_t        m_out;
  logic         m_ovf;
  int           m_last;
  logic [W-1:0] seen[$];
  int           seen_cyc[$];

  flit_t a[8];
  flit_t b[8];
  flit_t s[20];
  flit_t f;
  flit_t h;
  int    pushed;

  rr_merge_node #(
    .log_n_add      (LOG_N_ADD),
    .bit_width      (BIT_WIDTH),
    .val_bit        (VAL_BIT),
    .log_buffer_len (LOG_BUFFER_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_1     (in_1),
    .in_2     (in_2),
    .full_1   (full_1),
    .full_2   (full_2),
    .out      (out),
    .full_out (full_out),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic flit_t rnd_flit();
    flit_t r;
    r.valid = 1'b1;
    r.dest  = LOG_N_ADD'($urandom);
    r.data  = BIT_WIDTH'($urandom);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_out  = '0;
    m_ovf  = 1'b0;
    m_last = 2;
  endtask

  // One rising edge of the merge node, stated in queue terms.
  task automatic model_edge(input flit_t ia, input flit_t ib, input logic fo);
    bit f1, f2;
    int w;
    f1 = (q1.size() == DEPTH);
    f2 = (q2.size() == DEPTH);
    w  = 0;
    if (!m_out.valid || !fo) begin
      if (q1.size() != 0 && q2.size() != 0) w = (m_last == 1) ? 2 : 1;
      else if (q1.size() != 0)              w = 1;
      else if (q2.size() != 0)              w = 2;
      if (w == 1) begin
        m_out  = q1.pop_front();
        m_last = 1;
      end else if (w == 2) begin
        m_out  = q2.pop_front();
        m_last = 2;
      end else begin
        m_out = '0;
      end
    end
    if (ia.valid) begin
      if (f1) m_ovf = 1'b1;
      else    q1.push_back(ia);
    end
    if (ib.valid) begin
      if (f2) m_ovf = 1'b1;
      else    q2.push_back(ib);
    end
  endtask

  task automatic cycle(input flit_t ia, input flit_t ib, input logic fo);
    in_1     = ia;
    in_2     = ib;
    full_out = fo;
    if (out[W-1] && !fo) begin
      seen.push_back(out);
      seen_cyc.push_back(cyc);
    end
    @(posedge clk);
    model_edge(ia, ib, fo);
    cyc++;
    @(negedge clk);
    chk("out", 32'(out), 32'(m_out));
    chk("full_1", 32'(full_1), 32'(q1.size() == DEPTH));
    chk("full_2", 32'(full_2), 32'(q2.size() == DEPTH));
    chk("ovf", 32'(ovf), 32'(m_ovf));
  endtask

  task automatic clear_seen();
    seen.delete();
    seen_cyc.delete();
  endtask

  initial begin
    // T1: reset holds everything cleared regardless of inputs.
    model_reset();
    for (int i = 0; i < 3; i++) begin
      in_1     = W'($urandom);
      in_2     = W'($urandom);
      full_out = 1'($urandom);
      @(negedge clk);
      chk("t1_out", 32'(out), 32'd0);
      chk("t1_full_1", 32'(full_1), 32'd0);
      chk("t1_full_2", 32'(full_2), 32'd0);
      chk("t1_ovf", 32'(ovf), 32'd0);
    end
    rst = 1'b1;
    for (int i = 0; i < 2; i++) cycle(IDLE, IDLE, 1'b0);

    // T3: fresh after reset, so input 1 wins the first contention.
    clear_seen();
    for (int i = 0; i < 4; i++) begin
      a[i] = rnd_flit();
      b[i] = rnd_flit();
    end
    for (int i = 0; i < 4; i++) cycle(a[i], b[i], 1'b0);
    for (int i = 0; i < 7; i++) cycle(IDLE, IDLE, 1'b0);
    chk("t3_count", 32'(seen.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("t3_order", 32'(seen[i]), 32'((i % 2 == 0) ? a[i/2] : b[i/2]));
      chk("t3_no_bubble", 32'(seen_cyc[i] - seen_cyc[0]), 32'(i));
    end

    // T2: single flit on input 1, two edges of latency, then a bubble.
    f.valid = 1'b1;
    f.dest  = 6'd5;
    f.data  = 16'hABCD;
    cycle(f, IDLE, 1'b0);
    chk("t2_not_yet", 32'(out[W-1]), 32'd0);
    cycle(IDLE, IDLE, 1'b0);
    chk("t2_out", 32'(out), 32'h5_ABCD | 32'(1 << (W - 1)));
    cycle(IDLE, IDLE, 1'b0);
    chk("t2_clear", 32'(out[W-1]), 32'd0);

    // T4: input 1 won last, so input 2 leads; out holds for five blocked cycles.
    clear_seen();
    for (int i = 0; i < 3; i++) begin
      a[i] = rnd_flit();
      b[i] = rnd_flit();
    end
    cycle(a[0], b[0], 1'b0);
    cycle(a[1], b[1], 1'b0);
    cycle(a[2], b[2], 1'b1);
    chk("t4_hold", 32'(out), 32'(b[0]));
    for (int i = 0; i < 4; i++) begin
      cycle(IDLE, IDLE, 1'b1);
      chk("t4_hold", 32'(out), 32'(b[0]));
    end
    for (int i = 0; i < 8; i++) cycle(IDLE, IDLE, 1'b0);
    chk("t4_count", 32'(seen.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      chk("t4_order", 32'(seen[i]), 32'((i % 2 == 0) ? b[i/2] : a[i/2]));

    // T5: fill input 1 behind a held output, overflow, then a push into a full FIFO at release.
    clear_seen();
    h = rnd_flit();
    cycle(h, IDLE, 1'b1);
    cycle(IDLE, IDLE, 1'b1);
    chk("t5_held", 32'(out), 32'(h));
    for (int i = 0; i < 8; i++) begin
      a[i] = rnd_flit();
      cycle(a[i], IDLE, 1'b1);
      if (i == 6) chk("t5_not_full", 32'(full_1), 32'd0);
    end
    chk("t5_full", 32'(full_1), 32'd1);
    chk("t5_no_ovf", 32'(ovf), 32'd0);
    cycle(rnd_flit(), IDLE, 1'b1);
    chk("t5_ovf", 32'(ovf), 32'd1);
    cycle(rnd_flit(), IDLE, 1'b0);
    for (int i = 0; i < 12; i++) cycle(IDLE, IDLE, 1'b0);
    chk("t5_count", 32'(seen.size()), 32'd9);
    chk("t5_first", 32'(seen[0]), 32'(h));
    for (int i = 0; i < 8; i++) chk("t5_order", 32'(seen[i+1]), 32'(a[i]));

    // T6: 20 flits through input 2 with random backpressure, wrapping the pointers.
    clear_seen();
    for (int i = 0; i < 20; i++) s[i] = rnd_flit();
    pushed = 0;
    for (int t = 0; t < 400 && pushed < 20; t++) begin
      if (q2.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        cycle(IDLE, s[pushed], 1'($urandom_range(0, 1)));
        pushed++;
      end else begin
        cycle(IDLE, IDLE, 1'($urandom_range(0, 1)));
      end
    end
    chk("t6_pushed", 32'(pushed), 32'd20);
    for (int i = 0; i < 30; i++) cycle(IDLE, IDLE, 1'b0);
    chk("t6_count", 32'(seen.size()), 32'd20);
    for (int i = 0; i < 20; i++) chk("t6_order", 32'(seen[i]), 32'(s[i]));

    // Reset mid-stream: out clears without waiting for an edge.
    for (int i = 0; i < 3; i++) cycle(IDLE, rnd_flit(), 1'b1);
    cycle(IDLE, IDLE, 1'b1);
    chk("t6_pre_valid", 32'(out[W-1]), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_out", 32'(out), 32'd0);
    chk("t6_rst_full_2", 32'(full_2), 32'd0);
    chk("t6_rst_ovf", 32'(ovf), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(IDLE, IDLE, 1'b0);
    chk("t6_empty_after", 32'(out), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
